// File: rtl/img_loader_pkg.sv
// Shared definitions for the image loader: FSM state encoding,
// data-memory command codes and header length.
package img_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_W,
        ST_HDR_H,
        ST_LOAD,
        ST_CKSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    // Data memory command codes, shared with the memory and the control unit.
    localparam logic [1:0] MEM_WR = 2'b10;
    localparam logic [1:0] MEM_RD = 2'b00;

    // Header is width byte then height byte, stored at addresses 0 and 1.
    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/img_loader_if.sv
// Stream-in / memory-write bundle for the image loader.
// master = loader side, slave = stream source plus memory side.
interface img_loader_if #(
    parameter int ADDR_W = 19
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [1:0]        mem_write;

    modport master (
        input  s_data, s_valid,
        output s_ready, mem_addr, mem_din, mem_write
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, mem_addr, mem_din, mem_write
    );
endinterface

// File: rtl/img_loader_cksum8.sv
// 8-bit modulo-256 running sum of accepted pixel bytes.
// Clear has priority over enable.
module img_cksum8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);
    logic [7:0] sum_q, sum_d;

    // Next sum: clear on a new load, accumulate on each pixel transfer.
    always_comb begin
        sum_d = sum_q;
        if (clr_i)
            sum_d = 8'h00;
        else if (en_i)
            sum_d = sum_q + data_i;
    end

    // Sum register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst)
            sum_q <= 8'h00;
        else
            sum_q <= sum_d;
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/img_loader.sv
// Image loader: receives a width/height header plus raster pixels over a
// valid/ready byte stream and writes them into the data memory with one
// cycle of latency. Header lands at 0/1, pixels from PIX_BASE upward.
// Optional trailing checksum byte: define IMG_LOADER_CKSUM_EN.
module img_loader
    import img_loader_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int MEM_BYTES = 524288,
    parameter int PIX_BASE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    img_loader_if.master       bus,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               cksum_err
);
    state_e            state_q, state_d;
    logic [7:0]        width_q, width_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;   // next pixel address
    logic [15:0]       rem_q, rem_d;       // pixels still to come
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        mdin_q, mdin_d;
    logic [1:0]        mwr_q, mwr_d;

    logic              ready_w;
    logic              xfer_w;
    logic [15:0]       count_w;
    logic [31:0]       need_w;

`ifdef IMG_LOADER_CKSUM_EN
    logic              ckerr_q, ckerr_d;
    logic              ck_clr_w;
    logic              ck_en_w;
    logic [7:0]        ck_sum_w;

    img_cksum8 u_cksum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ck_clr_w),
        .en_i   (ck_en_w),
        .data_i (bus.s_data),
        .sum_o  (ck_sum_w)
    );

    assign ck_clr_w  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign ck_en_w   = xfer_w && (state_q == ST_LOAD);
    assign ready_w   = (state_q == ST_HDR_W) || (state_q == ST_HDR_H) ||
                       (state_q == ST_LOAD)  || (state_q == ST_CKSUM);
    assign cksum_err = ckerr_q;
`else
    assign ready_w   = (state_q == ST_HDR_W) || (state_q == ST_HDR_H) ||
                       (state_q == ST_LOAD);
    assign cksum_err = 1'b0;
`endif

    // Ready is a pure state decode so it never depends on s_valid.
    assign xfer_w  = bus.s_valid && ready_w;
    // Pixel count uses the height byte live on the bus in HDR_H.
    assign count_w = 16'(width_q) * 16'(bus.s_data);
    assign need_w  = 32'(PIX_BASE) + {16'd0, count_w};

    assign bus.s_ready   = ready_w;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_din   = mdin_q;
    assign bus.mem_write = mwr_q;
    assign busy = (state_q == ST_HDR_W) || (state_q == ST_HDR_H) || (state_q == ST_LOAD);
    assign done = (state_q == ST_DONE);
    assign err  = (state_q == ST_ERR);

    // Next-state, counters and the registered write strobe for each accepted byte.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        paddr_d = paddr_q;
        rem_d   = rem_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        mwr_d   = MEM_RD;
`ifdef IMG_LOADER_CKSUM_EN
        ckerr_d = ckerr_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_W;
                    width_d = 8'h00;
                    paddr_d = ADDR_W'(PIX_BASE);
                    rem_d   = 16'd0;
`ifdef IMG_LOADER_CKSUM_EN
                    ckerr_d = 1'b0;
`endif
                end
            end
            ST_HDR_W: begin
                if (xfer_w) begin
                    width_d = bus.s_data;
                    maddr_d = '0;
                    mdin_d  = bus.s_data;
                    mwr_d   = MEM_WR;
                    state_d = ST_HDR_H;
                end
            end
            ST_HDR_H: begin
                if (xfer_w) begin
                    maddr_d = ADDR_W'(HDR_BYTES - 1);
                    mdin_d  = bus.s_data;
                    mwr_d   = MEM_WR;
                    if (count_w == 16'd0) begin
`ifdef IMG_LOADER_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else if (need_w > 32'(MEM_BYTES)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                        paddr_d = ADDR_W'(PIX_BASE);
                        rem_d   = count_w;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer_w) begin
                    maddr_d = paddr_q;
                    mdin_d  = bus.s_data;
                    mwr_d   = MEM_WR;
                    paddr_d = paddr_q + 1'b1;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
`ifdef IMG_LOADER_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef IMG_LOADER_CKSUM_EN
            ST_CKSUM: begin
                // Trailing byte is compared only, never written to memory.
                if (xfer_w) begin
                    ckerr_d = (bus.s_data != ck_sum_w);
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            width_q <= 8'h00;
            paddr_q <= '0;
            rem_q   <= 16'd0;
            maddr_q <= '0;
            mdin_q  <= 8'h00;
            mwr_q   <= MEM_RD;
`ifdef IMG_LOADER_CKSUM_EN
            ckerr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            paddr_q <= paddr_d;
            rem_q   <= rem_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
            mwr_q   <= mwr_d;
`ifdef IMG_LOADER_CKSUM_EN
            ckerr_q <= ckerr_d;
`endif
        end
    end
endmodule

// File: doc/img_loader.md
Name: img_loader

Overview:
- Upstream neighbour of the data memory; fills it with one image before the downsampling core runs.
- Accepts a byte stream over valid/ready: a 2-byte header (width, height), then width*height pixel bytes in raster order.
- Drives the data memory write port with addresses, data and the write command.
- Raises done when the image is resident, so the processor can be released from hold.

Parameters:
- ADDR_W, 19, data memory address width.
- MEM_BYTES, 524288, usable memory bytes; the pixel-range check is made against this.
- PIX_BASE, 2, address of the first pixel byte. Header bytes go to addresses 0 and 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless the state is IDLE, DONE or ERR.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader can accept a byte.
- mem_addr  out  ADDR_W  to the data memory address input.
- mem_din  out  8  to the data memory write data.
- mem_write  out  2  2'b10 = write, 2'b00 = idle/read.
- busy  out  1  high in HDR_W, HDR_H and LOAD.
- done  out  1  high in DONE, held until the next start or rst.
- err  out  1  high in ERR, held until the next start or rst.
- cksum_err  out  1  checksum mismatch flag; see Optional Feature.

Behaviour:
- Reset (rst sampled high on a clk edge), valid from that edge onward:
  - state = IDLE.
  - s_ready, busy, done, err, cksum_err = 0.
  - mem_write = 2'b00; mem_addr = 0; mem_din = 0.
  - Internal counters and registers cleared.
  - Reset mid-load abandons the load; bytes already written stay in memory.
- Handshake: a byte transfers on a clk edge where s_valid && s_ready.
  - s_ready = 1 only in HDR_W, HDR_H and LOAD (and CKSUM when the feature is compiled in).
  - s_ready depends on state only, never combinationally on s_valid.
- Write timing: an accepted byte is written with 1-cycle latency.
  - On the edge after the transfer, mem_addr/mem_din/mem_write = 2'b10 are registered and held for exactly one cycle; the memory commits on the following edge.
  - mem_write returns to 2'b00 in every cycle without a transfer.
  - Back-to-back transfers give a continuous write strobe, 1 byte per cycle.
- State machine:
  - IDLE/DONE/ERR --start--> HDR_W.
  - HDR_W: byte -> width register, written at address 0; go to HDR_H.
  - HDR_H: byte -> height register, written at address 1. Compute count = width*height as a 16-bit unsigned value, then:
    - count == 0 -> DONE.
    - PIX_BASE + count > MEM_BYTES -> ERR. The header write still occurs; no pixel writes.
    - otherwise -> LOAD, with pixel address = PIX_BASE and the remaining-pixel counter = count.
  - LOAD: each byte is written at the current pixel address, then address +1 and remaining -1. The transfer that makes remaining 0 moves to DONE (or CKSUM).
- done and busy change on the same edge as the state register.
- The final write strobe is emitted in the first DONE cycle.
- start while busy is ignored; the stream is not flushed.
- start and rst on the same edge: rst wins.
- The address never wraps: the range check in HDR_H guarantees every pixel address is below MEM_BYTES.

Optional Feature:
- Macro: IMG_LOADER_CKSUM_EN.
- Defined:
  - After the last pixel, state CKSUM accepts one more byte, which is not written to memory.
  - It is compared to the 8-bit modulo sum of all pixel bytes; header bytes are excluded.
  - Mismatch -> cksum_err = 1 and DONE. Match -> cksum_err = 0 and DONE.
  - cksum_err is cleared by start or rst.
  - For count == 0, the CKSUM byte is expected to be 8'h00.
- Undefined: no CKSUM state; cksum_err is tied to 0.

Decomposition:
- Package img_loader_pkg holds:
  - state encoding: IDLE, HDR_W, HDR_H, LOAD, CKSUM, DONE, ERR;
  - MEM_WR = 2'b10 and MEM_RD = 2'b00, shared with the memory and the control unit;
  - HDR_BYTES = 2.
- One natural sub-module: img_cksum8, an accumulator with clear/enable and an 8-bit sum output; instantiated only under IMG_LOADER_CKSUM_EN.

Test Plan:
- Nominal load: start, stream 2, 3, then 6 pixels 8'h10..8'h15 with s_valid held high.
  - Writes at addresses 0, 1, 2..7 with data 2, 3, 10..15, one per cycle.
  - done rises in the cycle of the last strobe; busy falls at the same time.
- Bubbles: the same stream with s_valid low on alternate cycles.
  - Identical memory contents and address sequence.
  - mem_write = 2'b10 only in cycles following a transfer.
- Zero size: header 0, 5.
  - Writes only at addresses 0 and 1, then DONE with err = 0.
  - s_ready = 0 afterwards.
- Overflow: PIX_BASE = 524200, header 255, 255.
  - ERR and err = 1 after the height byte.
  - No write to any address ≥ 524200.
- Reset mid-load: rst asserted after 3 pixels of a 2x3 image.
  - Next cycle: IDLE, all outputs 0.
  - A new start followed by a full stream loads correctly.
- With IMG_LOADER_CKSUM_EN, pixels 1, 2, 3, 4 (header 2, 2):
  - trailing 8'h0A -> done = 1, cksum_err = 0;
  - trailing 8'h0B -> done = 1, cksum_err = 1.
